kalman_tracker_mc: RTL and testbench
====================================

Name: kalman_tracker_mc

Overview:
- Multi-channel alpha-beta (steady-state Kalman) position/velocity tracker for scrape streams.
- Each accepted measurement runs a real predict step (x+v), then a gated update with shift-based gains, per channel.
- Adds first-sample initialisation, coast (predict-only) requests, outlier gating, saturation and valid/ready handshaking on both sides.
- Sits between the scrape front-end and the glyph stage.

Parameters:
- WIDTH, 16, signed fixed-point width of measurement, position and velocity.
- CHANNELS, 4, number of independent tracks.
- CH_W, 2, channel-id width; must satisfy 2^CH_W >= CHANNELS.
- ALPHA_SHIFT, 2, position gain = 2^-ALPHA_SHIFT.
- BETA_SHIFT, 4, velocity gain = 2^-BETA_SHIFT.
- GATE, 16'h0400, innovation magnitude limit (unsigned).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous clear of all channel state, one-cycle pulse.
- in_valid  in  1  measurement/request valid.
- in_ready  out  1  block can accept.
- in_ch  in  CH_W  channel id.
- in_meas  in  WIDTH  signed measurement; ignored when in_coast=1.
- in_coast  in  1  predict-only request, no measurement.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_ch  out  CH_W  channel of result.
- out_pos  out  WIDTH  signed updated position estimate.
- out_vel  out  WIDTH  signed updated velocity estimate.
- out_gated  out  1  measurement rejected by the gate.
- out_init  out  1  this result initialised the channel.

Behaviour:
- State per channel: x[c], v[c] (signed WIDTH), init[c] (1 bit).
- Reset and clr values: all state 0. Outputs: out_valid=0, out_ch/out_pos/out_vel/out_gated/out_init all 0. FSM to IDLE. in_ready=1 the cycle after reset/clr releases.
- FSM states: IDLE -> PRED -> UPD -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch ch/meas/coast and go to PRED.
- PRED: xp = sat(x[ch]+v[ch]) in WIDTH+1-bit intermediate; vp = v[ch].
- UPD: r = meas - xp in WIDTH+1 bits, signed.
  - Case init[ch]=0 and coast=0: x=meas, v=0, init[ch]=1, out_init=1.
  - Case init[ch]=0 and coast=1: no state change; output 0/0; gated=0; init=0.
  - Case coast=1 (channel initialised): x=xp, v=vp, gated=0.
  - Case |r| > GATE: x=xp, v=vp, gated=1.
  - Otherwise: x=sat(xp + (r>>>ALPHA_SHIFT)), v=sat(vp + (r>>>BETA_SHIFT)).
  - Shifts are arithmetic (round toward -inf).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Write-back to x[ch]/v[ch] happens in UPD; output registers load in the same cycle.
- OUT: out_valid=1 with stable data until out_ready=1, then go to IDLE (out_valid=0 next cycle).
- Latency: accept at edge T -> out_valid high from T+3. Max throughput 1 per 4 cycles with out_ready held high.
- in_ready=0 in PRED/UPD/OUT; in_valid in those states is ignored, not queued.
- clr in any state: aborts any in-flight transaction (no write-back if before UPD edge; results discarded). out_valid=0 next cycle, FSM to IDLE, all channels cleared. rst has identical effect.
- in_ch >= CHANNELS: accepted, no state change, result 0/0 with gated=1.

Test Plan:
- Init: rst, then ch0 meas 100 -> out_valid exactly 3 cycles after accept; ch0, pos 100, vel 0, init=1, gated=0.
- Update: ch0 meas 120 -> xp=100, r=20 -> pos 105, vel 1. Then coast ch0 -> pos 106, vel 1.
- Gating and negative floor shift:
  - ch0 meas 5000 -> r=4893 > 1024 -> pos 107, vel 1, gated=1.
  - ch1 meas 0 then meas -3 -> pos -1, vel -1.
- Saturation (GATE=16'h7FFF): ch2 meas 32000, meas 32767 -> pos 32191, vel 47. 12 coasts -> pos 32755; 13th and later -> pos 32767, vel 47.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_* stable, in_ready=0, no extra accept. out_ready=1 -> single beat, then next accept.
- clr asserted in UPD of a ch3 init -> no output beat; subsequent ch0 meas 50 -> init=1, pos 50, vel 0; ch3 coast -> 0/0, init=0.

Source files
------------

// File: rtl/kalman_tracker_mc_if.sv
// Measurement-in / estimate-out stream bundle for the alpha-beta tracker.
// master drives requests and consumes results; slave is the tracker itself.
interface kalman_tracker_mc_if #(
  parameter int WIDTH = 16,
  parameter int CH_W  = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic signed [WIDTH-1:0] in_meas;
  logic                    in_coast;

  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] out_pos;
  logic signed [WIDTH-1:0] out_vel;
  logic                    out_gated;
  logic                    out_init;

  modport master (
    output in_valid, in_ch, in_meas, in_coast, out_ready,
    input  in_ready, out_valid, out_ch, out_pos, out_vel, out_gated, out_init
  );

  modport slave (
    input  in_valid, in_ch, in_meas, in_coast, out_ready,
    output in_ready, out_valid, out_ch, out_pos, out_vel, out_gated, out_init
  );
endinterface

// File: rtl/kalman_tracker_mc.sv
// Multi-channel alpha-beta position/velocity tracker.
// One request at a time walks IDLE -> PRED -> UPD -> OUT; per-channel x/v/init
// state is read in PRED and written back at the end of UPD.
module kalman_tracker_mc #(
  parameter int              WIDTH       = 16,
  parameter int              CHANNELS    = 4,
  parameter int              CH_W        = 2,
  parameter int              ALPHA_SHIFT = 2,
  parameter int              BETA_SHIFT  = 4,
  parameter logic [WIDTH-1:0] GATE       = 16'h0400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  kalman_tracker_mc_if.slave bus
);

  // Two guard bits so every sum below is exact before clamping.
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PRED, S_UPD, S_OUT} state_t;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return a[WIDTH-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic                    in_ready_c;

  logic [CH_W-1:0]         ch_q;
  logic signed [WIDTH-1:0] meas_q;
  logic                    coast_q;
  logic signed [WIDTH-1:0] xp_q, vp_q;

  logic signed [WIDTH-1:0] x_q [CHANNELS];
  logic signed [WIDTH-1:0] v_q [CHANNELS];
  logic [CHANNELS-1:0]     init_q;

  logic                    out_valid_q;
  logic [CH_W-1:0]         out_ch_q;
  logic signed [WIDTH-1:0] out_pos_q, out_vel_q;
  logic                    out_gated_q, out_init_q;

  logic signed [WIDTH-1:0] x_sel, v_sel;
  logic                    init_sel, ch_ok;
  logic signed [EW-1:0]    pred_sum;
  logic signed [WIDTH-1:0] xp_c;
  logic signed [WIDTH:0]   resid, r_a, r_b;
  logic [WIDTH:0]          resid_abs;
  logic                    gate_hit;
  logic signed [EW-1:0]    upd_x_sum, upd_v_sum;

  logic signed [WIDTH-1:0] new_x, new_v;
  logic                    new_gated, new_init, wr_en, set_init;
  logic [CHANNELS-1:0]     wr_sel;

  // Select the addressed channel's state; ids beyond CHANNELS read as empty.
  always_comb begin
    x_sel    = '0;
    v_sel    = '0;
    init_sel = 1'b0;
    ch_ok    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CH_W'(c)) begin
        x_sel    = x_q[c];
        v_sel    = v_q[c];
        init_sel = init_q[c];
        ch_ok    = 1'b1;
      end
    end
  end

  assign pred_sum  = {{2{x_sel[WIDTH-1]}}, x_sel} + {{2{v_sel[WIDTH-1]}}, v_sel};
  assign xp_c      = sat(pred_sum);

  assign resid     = {meas_q[WIDTH-1], meas_q} - {xp_q[WIDTH-1], xp_q};
  assign resid_abs = resid[WIDTH] ? ({(WIDTH+1){1'b0}} - resid) : resid;
  assign gate_hit  = resid_abs > {1'b0, GATE};
  assign r_a       = resid >>> ALPHA_SHIFT;
  assign r_b       = resid >>> BETA_SHIFT;
  assign upd_x_sum = {{2{xp_q[WIDTH-1]}}, xp_q} + {r_a[WIDTH], r_a};
  assign upd_v_sum = {{2{vp_q[WIDTH-1]}}, vp_q} + {r_b[WIDTH], r_b};

  // Update-step decision: what gets written back and what gets reported.
  always_comb begin
    new_x     = xp_q;
    new_v     = vp_q;
    new_gated = 1'b0;
    new_init  = 1'b0;
    wr_en     = 1'b0;
    set_init  = 1'b0;
    if (!ch_ok) begin
      new_x     = '0;
      new_v     = '0;
      new_gated = 1'b1;
    end else if (!init_sel && !coast_q) begin
      new_x    = meas_q;
      new_v    = '0;
      new_init = 1'b1;
      wr_en    = 1'b1;
      set_init = 1'b1;
    end else if (!init_sel) begin
      new_x = '0;
      new_v = '0;
    end else if (coast_q) begin
      wr_en = 1'b1;
    end else if (gate_hit) begin
      new_gated = 1'b1;
      wr_en     = 1'b1;
    end else begin
      new_x = sat(upd_x_sum);
      new_v = sat(upd_v_sum);
      wr_en = 1'b1;
    end
  end

  // Per-channel write strobe, only at the UPD edge.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_wr
      localparam logic [CH_W-1:0] CH_ID = CH_W'(gi);
      assign wr_sel[gi] = (state_q == S_UPD) && wr_en && (ch_q == CH_ID);
    end
  endgenerate

  // FSM next state and input-side ready.
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = S_PRED;
      end
      S_PRED: state_d = S_UPD;
      S_UPD:  state_d = S_OUT;
      S_OUT:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register; clr aborts whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Request capture on accept, prediction capture in PRED.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      meas_q  <= '0;
      coast_q <= 1'b0;
      xp_q    <= '0;
      vp_q    <= '0;
    end else begin
      if (state_q == S_IDLE && bus.in_valid) begin
        ch_q    <= bus.in_ch;
        meas_q  <= bus.in_meas;
        coast_q <= bus.in_coast;
      end
      if (state_q == S_PRED) begin
        xp_q <= xp_c;
        vp_q <= v_sel;
      end
    end
  end

  // Channel state write-back.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        x_q[c] <= '0;
        v_q[c] <= '0;
      end
      init_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_sel[c]) begin
          x_q[c] <= new_x;
          v_q[c] <= new_v;
          if (set_init) init_q[c] <= 1'b1;
        end
      end
    end
  end

  // Result registers: loaded at the UPD edge, held while OUT waits for ready.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_pos_q   <= '0;
      out_vel_q   <= '0;
      out_gated_q <= 1'b0;
      out_init_q  <= 1'b0;
    end else begin
      out_valid_q <= (state_d == S_OUT);
      if (state_q == S_UPD) begin
        out_ch_q    <= ch_q;
        out_pos_q   <= new_x;
        out_vel_q   <= new_v;
        out_gated_q <= new_gated;
        out_init_q  <= new_init;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_pos   = out_pos_q;
  assign bus.out_vel   = out_vel_q;
  assign bus.out_gated = out_gated_q;
  assign bus.out_init  = out_init_q;

endmodule

// File: tb/tb_kalman_tracker_mc.sv
// Directed bench for kalman_tracker_mc. Two instances share the same stimulus:
// dut_a with the default gate, dut_b with the gate opened to 16'h7FFF for the
// saturation rows.
module tb_kalman_tracker_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, clr;
  logic               in_valid, in_coast, out_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_meas;

  kalman_tracker_mc_if #(.WIDTH(16), .CH_W(2)) bus_a ();
  kalman_tracker_mc_if #(.WIDTH(16), .CH_W(2)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_ch     = in_ch;
  assign bus_a.in_meas   = in_meas;
  assign bus_a.in_coast  = in_coast;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_ch     = in_ch;
  assign bus_b.in_meas   = in_meas;
  assign bus_b.in_coast  = in_coast;
  assign bus_b.out_ready = out_ready;

  kalman_tracker_mc dut_a (.clk(clk), .rst(rst), .clr(clr), .bus(bus_a));
  kalman_tracker_mc #(.GATE(16'h7FFF)) dut_b (.clk(clk), .rst(rst), .clr(clr), .bus(bus_b));

  typedef struct {
    int ch;
    int meas;
    bit coast;
    int pos;
    int vel;
    bit gated;
    bit init;
    bit use_b;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int ch, input int meas, input bit coast,
                         input int pos, input int vel, input bit gated, input bit init,
                         input bit use_b);
    vecs[i].ch = ch;     vecs[i].meas = meas;   vecs[i].coast = coast;
    vecs[i].pos = pos;   vecs[i].vel = vel;     vecs[i].gated = gated;
    vecs[i].init = init; vecs[i].use_b = use_b;
  endtask

  // Called right after the accept edge; returns how many negedges until out_valid.
  task automatic wait_out(input bit use_b, output int lat);
    logic ov;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      ov = use_b ? bus_b.out_valid : bus_a.out_valid;
    end while (!ov && lat < 12);
  endtask

  task automatic check_result(input vec_t v, input string tag);
    int pos, vel, ch;
    bit g, ini;
    if (v.use_b) begin
      pos = int'(bus_b.out_pos); vel = int'(bus_b.out_vel); ch = int'(bus_b.out_ch);
      g = bus_b.out_gated; ini = bus_b.out_init;
    end else begin
      pos = int'(bus_a.out_pos); vel = int'(bus_a.out_vel); ch = int'(bus_a.out_ch);
      g = bus_a.out_gated; ini = bus_a.out_init;
    end
    chk({tag, " ch"}, ch, v.ch);
    chk({tag, " pos"}, pos, v.pos);
    chk({tag, " vel"}, vel, v.vel);
    chk({tag, " gated"}, int'(g), int'(v.gated));
    chk({tag, " init"}, int'(ini), int'(v.init));
    $display("txn %s ch=%0d meas=%0d coast=%0d -> pos=%0d vel=%0d gated=%0d init=%0d",
             tag, v.ch, v.meas, v.coast, pos, vel, g, ini);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n, lat;
    @(negedge clk);
    n = 0;
    while (!bus_a.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, int'(bus_a.in_ready), 1);
    in_valid = 1'b1;
    in_ch    = v.ch[1:0];
    in_meas  = v.meas[15:0];
    in_coast = v.coast;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(v.use_b, lat);
    chk({tag, " latency"}, lat, 3);
    check_result(v, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    int lat;

    set_vec(0, 0, 100,   0, 100,  0,  0, 1, 0);
    set_vec(1, 0, 120,   0, 105,  1,  0, 0, 0);
    set_vec(2, 0, 0,     1, 106,  1,  0, 0, 0);
    set_vec(3, 0, 5000,  0, 107,  1,  1, 0, 0);
    set_vec(4, 1, 0,     0, 0,    0,  0, 1, 0);
    set_vec(5, 1, -3,    0, -1,   -1, 0, 0, 0);
    set_vec(6, 2, 32000, 0, 32000, 0, 0, 1, 1);
    set_vec(7, 2, 32767, 0, 32191, 47, 0, 0, 1);
    for (int k = 1; k <= 12; k++) set_vec(7 + k, 2, 0, 1, 32191 + 47 * k, 47, 0, 0, 1);
    set_vec(20, 2, 0, 1, 32767, 47, 0, 0, 1);
    set_vec(21, 2, 0, 1, 32767, 47, 0, 0, 1);
    set_vec(22, 3, 0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_coast = 1'b0;
    in_ch = '0; in_meas = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", int'(bus_a.out_valid), 0);
    chk("reset in_ready", int'(bus_a.in_ready), 1);
    chk("reset out_pos", int'(bus_a.out_pos), 0);
    chk("reset out_vel", int'(bus_a.out_vel), 0);
    chk("reset flags", int'({bus_a.out_gated, bus_a.out_init, bus_a.out_ch}), 0);

    for (int i = 0; i < NV; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready=0, extra in_valid ignored.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd1; in_meas = -16'sd2; in_coast = 1'b0;
    @(posedge clk);
    #1 in_meas = 16'sd100;
    wait_out(1'b0, lat);
    chk("bp latency", lat, 3);
    hv = '{ch: 1, meas: -2, coast: 0, pos: -2, vel: -1, gated: 0, init: 0, use_b: 0};
    check_result(hv, "bp_hold");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp out_valid held", int'(bus_a.out_valid), 1);
      chk("bp in_ready low", int'(bus_a.in_ready), 0);
      chk("bp out_pos stable", int'(bus_a.out_pos), -2);
      chk("bp out_vel stable", int'(bus_a.out_vel), -1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp single beat", int'(bus_a.out_valid), 0);
    chk("bp ready again", int'(bus_a.in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(1'b0, lat);
    chk("bp next latency", lat, 3);
    hv = '{ch: 1, meas: 100, coast: 0, pos: 22, vel: 5, gated: 0, init: 0, use_b: 0};
    check_result(hv, "bp_next");

    // clr while a ch3 init sits in UPD: no beat, all channels wiped.
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd3; in_meas = 16'sd7; in_coast = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    chk("clr in_ready", int'(bus_a.in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      chk("clr no beat", int'(bus_a.out_valid), 0);
      @(negedge clk);
    end
    hv = '{ch: 0, meas: 50, coast: 0, pos: 50, vel: 0, gated: 0, init: 1, use_b: 0};
    run_txn(hv, "clr_ch0");
    hv = '{ch: 3, meas: 0, coast: 1, pos: 0, vel: 0, gated: 0, init: 0, use_b: 0};
    run_txn(hv, "clr_ch3");
    hv = '{ch: 1, meas: 10, coast: 0, pos: 10, vel: 0, gated: 0, init: 1, use_b: 0};
    run_txn(hv, "clr_ch1");

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
